// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback stage and a multi-cycle unit (mult/div). Multi-cycle results are
// parked in a 2-entry FIFO. The pipeline normally wins the port. A pending
// FIFO entry that has lost STARVE_LIMIT times in a row forces a one-cycle
// pipeline stall so that it can drain.
//
// Ports
//   clk, rstn                   clock, synchronous active-low reset
//   ipipe_we/waddr/wdata        pipeline writeback request (waddr 0 = none)
//   imc_valid/waddr/wdata       multi-cycle result offer
//   omc_ready                   multi-cycle result accepted this cycle
//   ostall_pipe                 pipeline write refused; pipeline holds WB
//   oregfile_we/waddr/wdata     registered regfile write port
//   opending                    number of buffered multi-cycle results
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        ipipe_we,
   input  logic [4:0]  ipipe_waddr,
   input  logic [31:0] ipipe_wdata,
   input  logic        imc_valid,
   input  logic [4:0]  imc_waddr,
   input  logic [31:0] imc_wdata,
   output logic        omc_ready,
   output logic        ostall_pipe,
   output logic        oregfile_we,
   output logic [4:0]  oregfile_waddr,
   output logic [31:0] oregfile_wdata,
   output logic [1:0]  opending
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PEND  = 2'd1,
      S_FORCE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [3:0]  starve_q, starve_d;
   logic [4:0]  fifo_addr_q [2];
   logic [4:0]  fifo_addr_d [2];
   logic [31:0] fifo_data_q [2];
   logic [31:0] fifo_data_d [2];
   logic        we_q, we_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        pipe_req;
   logic        push;
   logic        pop;
   logic        grant_pipe;
   logic        drain_to_idle;
   logic [3:0]  starve_inc;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   // A write to r0 is architecturally a no-op, so it never competes for the port.
   assign pipe_req      = ipipe_we && (ipipe_waddr != 5'd0);
   assign omc_ready     = (count_q != 2'd2);
   assign push          = imc_valid && omc_ready;
   assign head_addr     = fifo_addr_q[rd_ptr_q];
   assign head_data     = fifo_data_q[rd_ptr_q];
   assign starve_inc    = starve_q + 4'd1;
   // Popping the last entry without a simultaneous push empties the FIFO.
   assign drain_to_idle = (count_q == 2'd1) && !push;
   assign ostall_pipe   = (state_q == S_FORCE);

   assign oregfile_we    = we_q;
   assign oregfile_waddr = waddr_q;
   assign oregfile_wdata = wdata_q;
   assign opending       = count_q;

   // Arbitration FSM: IDLE means the FIFO is empty, PEND means it holds at
   // least one entry, FORCE is the one-cycle starvation drain.
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      grant_pipe = 1'b0;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            starve_d   = 4'd0;
            grant_pipe = pipe_req;
            if (push) state_d = S_PEND;
         end
         S_PEND: begin
            if (pipe_req) begin
               grant_pipe = 1'b1;
               starve_d   = starve_inc;
               if (starve_inc == 4'(STARVE_LIMIT)) state_d = S_FORCE;
            end else begin
               pop      = 1'b1;
               starve_d = 4'd0;
               state_d  = drain_to_idle ? S_IDLE : S_PEND;
            end
         end
         S_FORCE: begin
            pop      = 1'b1;
            starve_d = 4'd0;
            state_d  = drain_to_idle ? S_IDLE : S_PEND;
         end
         default: begin
            state_d  = S_IDLE;
            starve_d = 4'd0;
         end
      endcase
   end

   // Two-entry FIFO; single-bit pointers wrap naturally.
   always_comb begin
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      if (push) begin
         fifo_addr_d[wr_ptr_q] = imc_waddr;
         fifo_data_d[wr_ptr_q] = imc_wdata;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Registered write port. Address/data hold their last value when idle;
   // only the enable is cleared. A FIFO entry targeting r0 is consumed
   // silently.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (grant_pipe) begin
         we_d    = 1'b1;
         waddr_d = ipipe_waddr;
         wdata_d = ipipe_wdata;
      end else if (pop) begin
         we_d    = (head_addr != 5'd0);
         waddr_d = head_addr;
         wdata_d = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         starve_q <= 4'd0;
         we_q     <= 1'b0;
         waddr_q  <= 5'd0;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   // FIFO storage is qualified by count_q, so it needs no reset.
   always_ff @(posedge clk) begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Directed scenarios for wb_port_arbiter. Each scenario task drives inputs
// just after a rising edge and pushes the regfile writes it expects onto a
// scoreboard queue. tick() advances one cycle and pops/compares whenever the
// DUT presents a write.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ipipe_we;
   logic [4:0]  ipipe_waddr;
   logic [31:0] ipipe_wdata;
   logic        imc_valid;
   logic [4:0]  imc_waddr;
   logic [31:0] imc_wdata;
   logic        omc_ready;
   logic        ostall_pipe;
   logic        oregfile_we;
   logic [4:0]  oregfile_waddr;
   logic [31:0] oregfile_wdata;
   logic [1:0]  opending;

   wr_t exp_q[$];
   int  tests_run    = 0;
   int  tests_failed = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .ipipe_we       (ipipe_we),
      .ipipe_waddr    (ipipe_waddr),
      .ipipe_wdata    (ipipe_wdata),
      .imc_valid      (imc_valid),
      .imc_waddr      (imc_waddr),
      .imc_wdata      (imc_wdata),
      .omc_ready      (omc_ready),
      .ostall_pipe    (ostall_pipe),
      .oregfile_we    (oregfile_we),
      .oregfile_waddr (oregfile_waddr),
      .oregfile_wdata (oregfile_wdata),
      .opending       (opending)
   );

   task automatic idle_inputs();
      ipipe_we    = 1'b0;
      ipipe_waddr = 5'd0;
      ipipe_wdata = 32'd0;
      imc_valid   = 1'b0;
      imc_waddr   = 5'd0;
      imc_wdata   = 32'd0;
   endtask

   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (oregfile_we === 1'b1) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL sb_unexpected_write: got reg %0d data 0x%08h, required no write",
                     oregfile_waddr, oregfile_wdata);
         end else begin
            e = exp_q.pop_front();
            if (oregfile_waddr !== e.addr || oregfile_wdata !== e.data) begin
               tests_failed++;
               $display("FAIL sb_write: got reg %0d data 0x%08h, required reg %0d data 0x%08h",
                        oregfile_waddr, oregfile_wdata, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      tick();
      tick();
      tests_run++;
      if (opending !== 2'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d, required 0", opending); end
      tests_run++;
      if (oregfile_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %0b, required 0", oregfile_we); end
      tests_run++;
      if (oregfile_waddr !== 5'd0) begin tests_failed++; $display("FAIL reset_waddr: got %0d, required 0", oregfile_waddr); end
      tests_run++;
      if (oregfile_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata: got 0x%08h, required 0", oregfile_wdata); end
      tests_run++;
      if (ostall_pipe !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %0b, required 0", ostall_pipe); end
      tests_run++;
      if (omc_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %0b, required 1", omc_ready); end
      rstn = 1'b1;
      tick();
      tests_run++;
      if (omc_ready !== 1'b1 || opending !== 2'd0) begin
         tests_failed++;
         $display("FAIL post_reset_idle: got ready %0b pending %0d, required ready 1 pending 0", omc_ready, opending);
      end
   endtask

   task automatic test_pipe_only();
      ipipe_we    = 1'b1;
      ipipe_waddr = 5'd5;
      ipipe_wdata = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      tests_run++;
      if (ostall_pipe !== 1'b0) begin tests_failed++; $display("FAIL pipe_stall: got %0b, required 0", ostall_pipe); end
      tick();
      idle_inputs();
      tests_run++;
      if (oregfile_we !== 1'b1) begin tests_failed++; $display("FAIL pipe_we: got %0b, required 1", oregfile_we); end
      tick();
      tests_run++;
      if (oregfile_we !== 1'b0) begin tests_failed++; $display("FAIL pipe_we_clear: got %0b, required 0", oregfile_we); end
      tick();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL pipe_drain: got %0d writes missing, required 0", exp_q.size()); end
   endtask

   task automatic test_idle_port();
      imc_valid = 1'b1;
      imc_waddr = 5'd9;
      imc_wdata = 32'h12;
      tests_run++;
      if (omc_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %0b, required 1", omc_ready); end
      exp_q.push_back({5'd9, 32'h12});
      tick();
      idle_inputs();
      tests_run++;
      if (opending !== 2'd1) begin tests_failed++; $display("FAIL idle_pending1: got %0d, required 1", opending); end
      tests_run++;
      if (oregfile_we !== 1'b0) begin tests_failed++; $display("FAIL idle_no_bypass: got we %0b, required 0", oregfile_we); end
      tick();
      tests_run++;
      if (opending !== 2'd0) begin tests_failed++; $display("FAIL idle_pending0: got %0d, required 0", opending); end
      tick();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL idle_drain: got %0d writes missing, required 0", exp_q.size()); end
   endtask

   // Entry pushed in IDLE alongside a pipeline write; then four losses in
   // PEND, one stall cycle draining reg 3, and the held pipeline write.
   task automatic test_starvation();
      int   a;
      logic exp_stall;
      a = 10;
      for (int i = 0; i < 8; i++) begin
         ipipe_we    = 1'b1;
         ipipe_waddr = 5'(a);
         ipipe_wdata = 32'hA000_0000 + 32'(a);
         imc_valid   = (i == 0);
         imc_waddr   = 5'd3;
         imc_wdata   = 32'h333;
         exp_stall   = (i == 5);
         tests_run++;
         if (ostall_pipe !== exp_stall) begin
            tests_failed++;
            $display("FAIL starve_stall_c%0d: got %0b, required %0b", i, ostall_pipe, exp_stall);
         end
         if (exp_stall) exp_q.push_back({5'd3, 32'h333});
         else begin
            exp_q.push_back({5'(a), 32'hA000_0000 + 32'(a)});
            a++;
         end
         tick();
      end
      idle_inputs();
      tick();
      tick();
      tests_run++;
      if (exp_q.size() != 0 || opending !== 2'd0) begin
         tests_failed++;
         $display("FAIL starve_drain: got %0d missing pending %0d, required 0 and 0", exp_q.size(), opending);
      end
   endtask

   task automatic test_full_fifo();
      logic       exp_rdy  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [1:0] exp_pend [7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
      for (int i = 0; i < 7; i++) begin
         idle_inputs();
         if (i < 3) begin
            ipipe_we    = 1'b1;
            ipipe_waddr = 5'(16 + i);
            ipipe_wdata = 32'hF000 + 32'(i);
            exp_q.push_back({5'(16 + i), 32'hF000 + 32'(i)});
         end
         if (i == 0) begin imc_valid = 1'b1; imc_waddr = 5'd20; imc_wdata = 32'hA; end
         if (i == 1) begin imc_valid = 1'b1; imc_waddr = 5'd21; imc_wdata = 32'hB; end
         if (i >= 2 && i <= 4) begin imc_valid = 1'b1; imc_waddr = 5'd22; imc_wdata = 32'hC; end
         if (i == 3) exp_q.push_back({5'd20, 32'hA});
         if (i == 4) exp_q.push_back({5'd21, 32'hB});
         if (i == 5) exp_q.push_back({5'd22, 32'hC});
         tests_run++;
         if (omc_ready !== exp_rdy[i]) begin
            tests_failed++;
            $display("FAIL full_ready_c%0d: got %0b, required %0b", i, omc_ready, exp_rdy[i]);
         end
         tests_run++;
         if (opending !== exp_pend[i]) begin
            tests_failed++;
            $display("FAIL full_pending_c%0d: got %0d, required %0d", i, opending, exp_pend[i]);
         end
         tick();
      end
      idle_inputs();
      tick();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL full_drain: got %0d writes missing, required 0", exp_q.size()); end
   endtask

   task automatic test_zero_reg();
      imc_valid = 1'b1;
      imc_waddr = 5'd7;
      imc_wdata = 32'h77;
      tick();
      imc_waddr   = 5'd0;
      imc_wdata   = 32'h55;
      ipipe_we    = 1'b1;
      ipipe_waddr = 5'd0;
      ipipe_wdata = 32'hBAD;
      exp_q.push_back({5'd7, 32'h77});
      tests_run++;
      if (ostall_pipe !== 1'b0 || opending !== 2'd1) begin
         tests_failed++;
         $display("FAIL zero_c1: got stall %0b pending %0d, required stall 0 pending 1", ostall_pipe, opending);
      end
      tick();
      imc_valid = 1'b0;
      tests_run++;
      if (opending !== 2'd1) begin tests_failed++; $display("FAIL zero_pending_c2: got %0d, required 1", opending); end
      tick();
      idle_inputs();
      tests_run++;
      if (opending !== 2'd0 || oregfile_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_entry_r0: got pending %0d we %0b, required pending 0 we 0", opending, oregfile_we);
      end
      tick();
      tick();
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL zero_drain: got %0d writes missing, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      ipipe_we = 1'b1; ipipe_waddr = 5'd1; ipipe_wdata = 32'h1111;
      imc_valid = 1'b1; imc_waddr = 5'd24; imc_wdata = 32'h24;
      exp_q.push_back({5'd1, 32'h1111});
      tick();
      ipipe_waddr = 5'd2; ipipe_wdata = 32'h2222;
      imc_waddr = 5'd25; imc_wdata = 32'h25;
      exp_q.push_back({5'd2, 32'h2222});
      tick();
      idle_inputs();
      tests_run++;
      if (opending !== 2'd2) begin tests_failed++; $display("FAIL rstmid_full: got %0d, required 2", opending); end
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tests_run++;
      if (opending !== 2'd0 || oregfile_we !== 1'b0 || ostall_pipe !== 1'b0 || omc_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_state: got pending %0d we %0b stall %0b ready %0b, required 0 0 0 1",
                  opending, oregfile_we, ostall_pipe, omc_ready);
      end
      for (int i = 0; i < 5; i++) tick();
      tests_run++;
      if (exp_q.size() != 0 || opending !== 2'd0) begin
         tests_failed++;
         $display("FAIL rstmid_after: got %0d missing pending %0d, required 0 and 0", exp_q.size(), opending);
      end
   endtask

   initial begin
      rstn = 1'b0;
      idle_inputs();
      test_reset();
      test_pipe_only();
      test_idle_port();
      test_starvation();
      test_full_fifo();
      test_zero_reg();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
